// File: rtl/mem_bus_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | mem_bus_arbiter_pkg: shared memory input bus type and idle constant  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_bus_arbiter_pkg;

  localparam logic [1:0] MEM_MODE_IDLE  = 2'b00;
  localparam logic [1:0] MEM_MODE_WRITE = 2'b01;

  typedef struct packed {
    logic [1:0]  mode;
    logic [31:0] address;
    logic [31:0] offset;
    logic [31:0] data;
  } mem_in_bus_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_t;

  function automatic mem_in_bus_t idle_mem_bus();
    mem_in_bus_t b;
    b      = '0;
    b.mode = MEM_MODE_IDLE;
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bus_arbiter_rr_pick.sv
// +----------------------------------------------------------------------+
// | mem_bus_arbiter_rr_pick: first unmasked requester, cyclic from ptr   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_bus_arbiter_rr_pick #(
  parameter int N_MASTERS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  input  logic [N_MASTERS-1:0] exclude,
  output logic                 found,
  output logic [IDX_W-1:0]     idx
);

  logic [N_MASTERS-1:0] cand;
  logic [IDX_W-1:0]     scan_pos;

  assign cand = req & ~exclude;

  // Wrap is an explicit compare so non-power-of-two N never aliases.
  always_comb begin
    found    = 1'b0;
    idx      = '0;
    scan_pos = ptr;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (!found && cand[scan_pos]) begin
        found = 1'b1;
        idx   = scan_pos;
      end
      scan_pos = (scan_pos == IDX_W'(N_MASTERS - 1)) ? '0 : scan_pos + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// +----------------------------------------------------------------------+
// | mem_bus_arbiter: registered round-robin grant for the mem_in bus     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter  int N_MASTERS = 4,
  parameter  int MAX_HOLD  = 8,
  localparam int IDX_W     = $clog2(N_MASTERS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic        [N_MASTERS-1:0]    req,
  input  mem_in_bus_t [N_MASTERS-1:0]    m_bus,
  output logic        [N_MASTERS-1:0]    grant,
  output logic                           grant_valid,
  output logic        [IDX_W-1:0]        grant_idx,
  output mem_in_bus_t                    mem_in
);

  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  arb_state_t           state, state_n;
  logic [N_MASTERS-1:0] grant_n;
  logic                 valid_n;
  logic [IDX_W-1:0]     idx_n;
  logic [IDX_W-1:0]     ptr, ptr_n;
  logic [HOLD_W-1:0]    hold_cnt, hold_n;
  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  logic                 take;

  // The owner is masked out, so one search serves both first grant and handoff.
  mem_bus_arbiter_rr_pick #(
    .N_MASTERS (N_MASTERS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .exclude (grant),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  always_comb begin
    state_n = state;
    grant_n = grant;
    valid_n = grant_valid;
    idx_n   = grant_idx;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    take    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (pick_found) take = 1'b1;
      end
      ST_OWNED: begin
        if (!req[grant_idx]) begin
          if (pick_found) begin
            take = 1'b1;
          end else begin
            state_n = ST_IDLE;
            grant_n = '0;
            valid_n = 1'b0;
            idx_n   = '0;
            hold_n  = '0;
          end
        end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && pick_found) begin
          take = 1'b1;
        end else if ((MAX_HOLD != 0) && (hold_cnt != HOLD_LAST)) begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: ;
    endcase

    if (take) begin
      state_n = ST_OWNED;
      grant_n = N_MASTERS'(1) << pick_idx;
      valid_n = 1'b1;
      idx_n   = pick_idx;
      hold_n  = '0;
      ptr_n   = (pick_idx == IDX_W'(N_MASTERS - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      ptr         <= '0;
      hold_cnt    <= '0;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      grant_valid <= valid_n;
      grant_idx   <= idx_n;
      ptr         <= ptr_n;
      hold_cnt    <= hold_n;
    end
  end

  // Driven only from registered grant state, so a non-owner never leaks through.
  always_comb begin
    mem_in = idle_mem_bus();
    if (grant_valid) mem_in = m_bus[grant_idx];
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_mem_bus_arbiter: three arbiter configurations against a model     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [3:0]            rq [3];
  mem_in_bus_t [3:0]     mb;

  logic [3:0]  g0, g1;
  logic [2:0]  g2;
  logic        v0, v1, v2;
  logic [1:0]  i0, i1, i2;
  mem_in_bus_t m0, m1, m2;

  mem_bus_arbiter #(.N_MASTERS(4), .MAX_HOLD(2)) dut_a (
    .clk(clk), .reset(rst), .req(rq[0]), .m_bus(mb),
    .grant(g0), .grant_valid(v0), .grant_idx(i0), .mem_in(m0));

  mem_bus_arbiter #(.N_MASTERS(4), .MAX_HOLD(0)) dut_b (
    .clk(clk), .reset(rst), .req(rq[1]), .m_bus(mb),
    .grant(g1), .grant_valid(v1), .grant_idx(i1), .mem_in(m1));

  mem_bus_arbiter #(.N_MASTERS(3), .MAX_HOLD(3)) dut_c (
    .clk(clk), .reset(rst), .req(rq[2][2:0]), .m_bus(mb[2:0]),
    .grant(g2), .grant_valid(v2), .grant_idx(i2), .mem_in(m2));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: owner (-1 = none), cycles owned so far, and where an idle search starts.
  int nn [3]   = '{4, 4, 3};
  int mh [3]   = '{2, 0, 3};
  int own [3]  = '{-1, -1, -1};
  int run [3]  = '{0, 0, 0};
  int mptr [3] = '{0, 0, 0};

  function automatic int first_req(input int n, input int from, input logic [3:0] r, input int skip);
    for (int k = 0; k < n; k++) begin
      int j;
      j = (from + k) % n;
      if (r[j] && j != skip) return j;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int nxt;
      if (rst) begin
        own[i] = -1; run[i] = 0; mptr[i] = 0;
      end else if (own[i] < 0) begin
        nxt = first_req(nn[i], mptr[i], rq[i], -1);
        if (nxt >= 0) begin
          own[i] = nxt; run[i] = 1; mptr[i] = (nxt + 1) % nn[i];
        end
      end else begin
        nxt = first_req(nn[i], (own[i] + 1) % nn[i], rq[i], own[i]);
        if (!rq[i][own[i]]) begin
          if (nxt >= 0) begin
            own[i] = nxt; run[i] = 1; mptr[i] = (nxt + 1) % nn[i];
          end else begin
            own[i] = -1; run[i] = 0;
          end
        end else if (mh[i] != 0 && run[i] >= mh[i] && nxt >= 0) begin
          own[i] = nxt; run[i] = 1; mptr[i] = (nxt + 1) % nn[i];
        end else begin
          run[i] = run[i] + 1;
        end
      end
    end
  end

  task automatic cmp(input int i, input logic [3:0] gr, input logic gv, input logic [1:0] gi,
                     input mem_in_bus_t mi);
    logic [3:0]  eg;
    mem_in_bus_t em;
    eg = 4'd0;
    em = '0;
    if (own[i] >= 0) begin
      eg = 4'd1 << own[i];
      em = mb[own[i]];
    end
    check($sformatf("model_grant%0d", i), 128'(gr), 128'(eg));
    check($sformatf("model_valid%0d", i), 128'(gv), 128'(own[i] >= 0));
    check($sformatf("model_idx%0d", i), 128'(gi), 128'((own[i] >= 0) ? own[i] : 0));
    check($sformatf("model_mem_in%0d", i), 128'(mi), 128'(em));
  endtask

  always @(negedge clk) begin
    cmp(0, g0, v0, i0, m0);
    cmp(1, g1, v1, i1, m1);
    cmp(2, {1'b0, g2}, v2, i2, m2);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int rr_exp [9]   = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int c_exp [6]    = '{0, 0, 0, 2, 2, 2};
  int c3_exp [10]  = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0};

  initial begin
    rst   = 1'b1;
    rq[0] = 4'd0; rq[1] = 4'd0; rq[2] = 4'd0;
    mb[0] = '{mode: MEM_MODE_WRITE, address: 32'h1000, offset: 32'h0, data: 32'h11111111};
    mb[1] = '{mode: MEM_MODE_WRITE, address: 32'h2000, offset: 32'h1, data: 32'h22222222};
    mb[2] = '{mode: MEM_MODE_WRITE, address: 32'h5555, offset: 32'h0, data: 32'h76767676};
    mb[3] = '{mode: MEM_MODE_IDLE,  address: 32'h4000, offset: 32'h3, data: 32'h44444444};

    tick(); tick();
    check("reset_grant", 128'(g0), 128'(4'b0000));
    check("reset_valid", 128'(v0), 128'(1'b0));
    check("reset_mode", 128'(m0.mode), 128'(2'b00));
    rst = 1'b0;
    tick();

    rq[0] = 4'b0100;
    tick();
    check("single_grant", 128'(g0), 128'(4'b0100));
    check("single_idx", 128'(i0), 128'(2'd2));
    check("single_addr", 128'(m0.address), 128'(32'h5555));
    check("single_data", 128'(m0.data), 128'(32'h76767676));
    check("single_mode", 128'(m0.mode), 128'(2'b01));
    rq[0] = 4'b0000;
    tick();
    check("release_valid", 128'(v0), 128'(1'b0));

    rst = 1'b1; tick(); rst = 1'b0;
    rq[0] = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      tick();
      check($sformatf("rr_idx%0d", k), 128'(i0), 128'(rr_exp[k]));
      check($sformatf("rr_valid%0d", k), 128'(v0), 128'(1'b1));
    end

    rq[0] = 4'b0000; rst = 1'b1; tick(); rst = 1'b0;
    rq[0] = 4'b0010;
    tick();
    check("handoff_owner", 128'(i0), 128'(2'd1));
    rq[0] = 4'b1010;
    tick();
    check("handoff_keep", 128'(g0), 128'(4'b0010));
    rq[0] = 4'b1000;
    tick();
    check("handoff_grant", 128'(g0), 128'(4'b1000));
    check("handoff_valid", 128'(v0), 128'(1'b1));
    rq[0] = 4'b0000;

    rq[1] = 4'b0101;
    for (int k = 0; k < 40; k++) begin
      tick();
      check($sformatf("unlimited%0d", k), 128'(g1), 128'(4'b0001));
    end
    rq[1] = 4'b0000;

    rq[2] = 4'b0101;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("hold3_idx%0d", k), 128'(i2), 128'(c_exp[k]));
    end
    rq[2] = 4'b0000;
    tick();
    rq[2] = 4'b0100;
    tick();
    check("n3_owner2", 128'(g2), 128'(3'b100));
    rst = 1'b1;
    tick();
    check("midreset_grant", 128'(g2), 128'(3'b000));
    check("midreset_valid", 128'(v2), 128'(1'b0));
    check("midreset_mode", 128'(m2.mode), 128'(2'b00));
    rst   = 1'b0;
    rq[2] = 4'b0111;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("n3_rr_idx%0d", k), 128'(i2), 128'(c3_exp[k]));
    end
    rq[2] = 4'b0000;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
